disk_ii_seq: RTL

Parametrised Disk II controller sequencer: decodes the slot's sixteen device-select soft switches, owns the motor/spindown timer, stepper-phase head positioning with optional half-track resolution, per-drive head position, and write-protect sensing. Issues a req/ack track-load handshake to the SDRAM track loader whenever the active drive's whole-track position changes. Sits between the A2 bus slot decode and the per-drive nibble data path, replacing the fixed two-drive soft-switch logic.

---
 rtl/disk_ii_seq_if.sv | 33 +++
 rtl/disk_ii_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/disk_ii_seq_if.sv
// disk_ii_seq_if: A2 slot bus, drive status and track-loader handshake bundle for disk_ii_seq
interface disk_ii_seq_if #(parameter int TRACKS = 35) ();
  localparam int HT_W = $clog2(2 * TRACKS - 1);
  localparam int TW = $clog2(TRACKS);
  logic dev_sel_i;
  logic [3:0] addr_i;
  logic rw_n_i;
  logic [7:0] latch_i;
  logic [1:0] wp_i;
  logic track_ack_i;
  logic [7:0] data_o;
  logic rd_en_o;
  logic [3:0] motor_phase_o;
  logic drive_on_o;
  logic drive_sel_o;
  logic q6_o;
  logic q7_o;
  logic [HT_W-1:0] ht0_o;
  logic [HT_W-1:0] ht1_o;
  logic track_req_o;
  logic track_drive_o;
  logic [TW-1:0] track_num_o;
  modport master (
    output dev_sel_i, addr_i, rw_n_i, latch_i, wp_i, track_ack_i,
    input data_o, rd_en_o, motor_phase_o, drive_on_o, drive_sel_o, q6_o, q7_o,
    input ht0_o, ht1_o, track_req_o, track_drive_o, track_num_o
  );
  modport slave (
    input dev_sel_i, addr_i, rw_n_i, latch_i, wp_i, track_ack_i,
    output data_o, rd_en_o, motor_phase_o, drive_on_o, drive_sel_o, q6_o, q7_o,
    output ht0_o, ht1_o, track_req_o, track_drive_o, track_num_o
  );
endinterface

// File: rtl/disk_ii_seq.sv
// disk_ii_seq: Disk II soft switches, spindown, stepper head positioning and track-load handshake (odd half-tracks with DISKII_HALFTRACK_EN)
module disk_ii_seq #(
  parameter int SPINDOWN_CYCLES = 14000000,
  parameter int TRACKS = 35,
  parameter int SD_W = 24
) (
  input logic clk_logic,
  input logic system_reset,
  disk_ii_seq_if.slave bus
);
  localparam int HT_MAX = 2 * TRACKS - 2;
  localparam int HT_W = $clog2(HT_MAX + 1);
  localparam int TW = $clog2(TRACKS);
`ifdef DISKII_HALFTRACK_EN
  localparam logic [HT_W-1:0] HT_MASK = '1;
`else
  localparam logic [HT_W-1:0] HT_MASK = ~HT_W'(1);
`endif
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [3:0] phase;
  logic motor, drive_sel, q6, q7, started, pending, prev_sel, req_drive;
  logic drive_on, tgt_ok, move, event_hit, sw;
  logic [SD_W-1:0] cnt;
  logic [HT_W-1:0] ht0, ht1, ht_sel, ht_nxt;
  logic [TW-1:0] trk, prev_trk, req_num;
  logic [2:0] tgt, d;
  int sum;
  assign sw = bus.dev_sel_i & bus.addr_i[3];
  assign drive_on = motor | (cnt != '0);
  assign ht_sel = drive_sel ? ht1 : ht0;
  assign trk = TW'(ht_sel >> 1);
  assign event_hit = !started | (trk != prev_trk) | (drive_sel != prev_sel);
  always_comb begin
    tgt_ok = 1'b0;
    tgt = '0;
    for (int k = 0; k < 4; k++) begin
      if (phase == (4'b0001 << k)) begin
        tgt_ok = 1'b1;
        tgt = 3'(2 * k);
      end
`ifdef DISKII_HALFTRACK_EN
      if (phase == ((4'b0011 << k) | (4'b0011 >> (4 - k)))) begin
        tgt_ok = 1'b1;
        tgt = 3'(2 * k + 1);
      end
`endif
    end
    d = tgt - ht_sel[2:0];
    move = drive_on & tgt_ok & (d inside {3'd1, 3'd2, 3'd6, 3'd7});
    sum = int'(ht_sel) + (d[2] ? int'(d) - 8 : int'(d));
    ht_nxt = HT_MASK & (sum < 0 ? '0 : sum > HT_MAX ? HT_W'(HT_MAX) : HT_W'(sum));
  end
  assign bus.rd_en_o = bus.dev_sel_i & bus.rw_n_i;
  assign bus.data_o = (!q6 && bus.addr_i == 4'hC) ? bus.latch_i :
                      (q6 && !q7 && !bus.addr_i[0]) ? {bus.wp_i[drive_sel], 7'b0} : 8'h00;
  assign bus.motor_phase_o = phase;
  assign bus.drive_on_o = drive_on;
  assign bus.drive_sel_o = drive_sel;
  assign bus.q6_o = q6;
  assign bus.q7_o = q7;
  assign bus.ht0_o = ht0;
  assign bus.ht1_o = ht1;
  assign bus.track_req_o = (state == REQ);
  assign bus.track_drive_o = req_drive;
  assign bus.track_num_o = req_num;
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      phase <= '0;
      motor <= 1'b0;
      drive_sel <= 1'b0;
      q6 <= 1'b0;
      q7 <= 1'b0;
      cnt <= '0;
      ht0 <= '0;
      ht1 <= '0;
    end else begin
      if (bus.dev_sel_i & !bus.addr_i[3]) phase[bus.addr_i[2:1]] <= bus.addr_i[0];
      if (sw & (bus.addr_i[2:1] == 2'd0)) motor <= bus.addr_i[0];
      if (sw & (bus.addr_i[2:1] == 2'd1)) drive_sel <= bus.addr_i[0];
      if (sw & (bus.addr_i[2:1] == 2'd2)) q6 <= bus.addr_i[0];
      if (sw & (bus.addr_i[2:1] == 2'd3)) q7 <= bus.addr_i[0];
      cnt <= motor ? ((sw & (bus.addr_i[2:0] == 3'b000)) ? SD_W'(SPINDOWN_CYCLES) : '0) :
             (cnt != '0 ? cnt - 1'b1 : '0);
      if (move & drive_sel) ht1 <= ht_nxt;
      if (move & !drive_sel) ht0 <= ht_nxt;
    end
  end
  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      state <= IDLE;
      pending <= 1'b0;
      started <= 1'b0;
      prev_trk <= '0;
      prev_sel <= 1'b0;
      req_drive <= 1'b0;
      req_num <= '0;
    end else begin
      started <= 1'b1;
      prev_trk <= trk;
      prev_sel <= drive_sel;
      if (state == IDLE ? event_hit : (bus.track_ack_i & (pending | event_hit))) begin
        req_drive <= drive_sel;
        req_num <= trk;
      end
      pending <= (state == REQ) & !bus.track_ack_i & (pending | event_hit);
      state <= (state == IDLE ? event_hit : (!bus.track_ack_i | pending | event_hit)) ? REQ : IDLE;
    end
  end
endmodule
